// File: rtl/sub_bytes_seq.sv
// AES SubBytes sequencer: streams the bytes of a state word through one shared
// registered S-box ROM and reassembles the substituted word behind a valid/ready pair.
module sub_bytes_seq #(
  parameter int NBYTES  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                sbox_en,
  output logic [7:0]          sbox_addr,
  input  logic [7:0]          sbox_data
);

  // state | meaning
  // IDLE  | ready for a new word
  // ISSUE | presenting one byte address per cycle to the ROM
  // DRAIN | waiting for the remaining lookups to return
  // DONE  | result held until downstream accepts it
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int         W    = 8 * NBYTES;
  localparam logic [4:0] NB   = 5'(NBYTES);
  localparam logic [3:0] LAST = 4'(NBYTES - 1);

  state_t         state, state_d;
  logic [4:0]     cnt, cnt_d;
  logic           en_d, ov_d, load, iss_v;
  logic [7:0]     addr_d, cur_byte;
  logic [3:0]     iss_idx;
  logic [W-1:0]   word_q;
  logic [RAM_LAT:0] tag_v;
  logic [3:0]     tag_idx [RAM_LAT+1];
  logic           last_retire;

  assign in_ready    = (state == IDLE);
  assign last_retire = tag_v[RAM_LAT] && (tag_idx[RAM_LAT] == LAST);

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NBYTES; k++)
      if (cnt == 5'(k)) cur_byte = word_q[W-1-8*k -: 8];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    en_d    = sbox_en;
    addr_d  = sbox_addr;
    ov_d    = out_valid;
    load    = 1'b0;
    iss_v   = 1'b0;
    iss_idx = '0;
    case (state)
      IDLE: if (in_valid) begin
        load    = 1'b1;
        en_d    = 1'b1;
        addr_d  = in_data[W-1 -: 8];
        cnt_d   = 5'd1;
        iss_v   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (cnt < NB) begin
        addr_d  = cur_byte;
        cnt_d   = cnt + 5'd1;
        iss_v   = 1'b1;
        iss_idx = cnt[3:0];
      end else begin
        en_d    = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: if (last_retire) begin
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over any handshake on the same edge
    if (flush) begin
      state_d = IDLE;
      en_d    = 1'b0;
      cnt_d   = '0;
      ov_d    = 1'b0;
      load    = 1'b0;
      iss_v   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sbox_en   <= 1'b0;
      sbox_addr <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_q    <= '0;
      tag_v     <= '0;
      for (int i = 0; i <= RAM_LAT; i++) tag_idx[i] <= '0;
    end else begin
      cnt       <= cnt_d;
      sbox_en   <= en_d;
      sbox_addr <= addr_d;
      out_valid <= ov_d;
      if (load) word_q <= in_data;
      // tag stage RAM_LAT lines up with the ROM data for that lookup
      if (!flush && tag_v[RAM_LAT]) begin
        for (int k = 0; k < NBYTES; k++)
          if (tag_idx[RAM_LAT] == 4'(k)) out_data[W-1-8*k -: 8] <= sbox_data;
      end
      if (flush) tag_v <= '0;
      else       tag_v <= {tag_v[RAM_LAT-1:0], iss_v};
      tag_idx[0] <= iss_idx;
      for (int i = 1; i <= RAM_LAT; i++) tag_idx[i] <= tag_idx[i-1];
    end
  end

endmodule
